// File: rtl/score_counter.sv
// Cascaded multi-digit up/down counter with parallel load, wrap/saturate
// overflow handling and a high-score register captured on clear.
module score_counter #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int DIGIT_MAX = 9,
  parameter int SATURATE  = 0
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_clr,
  input  logic                       i_load,
  input  logic [DIGITS*DIGIT_W-1:0]  i_load_val,
  input  logic                       i_inc,
  input  logic                       i_dec,
  output logic [DIGITS*DIGIT_W-1:0]  o_val,
  output logic [DIGITS*DIGIT_W-1:0]  o_hi,
  output logic                       o_carry,
  output logic                       o_borrow,
  output logic                       o_max,
  output logic                       o_zero
);

  localparam int W = DIGITS * DIGIT_W;
  localparam logic [DIGIT_W-1:0] DMAX = DIGIT_MAX[DIGIT_W-1:0];
  localparam logic [DIGIT_W-1:0] ONE  = DIGIT_W'(1);
  localparam bit WRAP = (SATURATE == 0);

  logic [W-1:0]       val_q;
  logic [W-1:0]       hi_q;
  logic               carry_q;
  logic               borrow_q;

  logic [DIGIT_W-1:0] digit    [DIGITS];
  logic [DIGIT_W-1:0] ld_digit [DIGITS];
  logic [W-1:0]       inc_val;
  logic [W-1:0]       dec_val;
  logic [W-1:0]       load_clamped;
  logic               all_max;
  logic               all_zero;
  logic               run_max;
  logic               run_zero;

  for (genvar g = 0; g < DIGITS; g++) begin : g_split
    assign digit[g]    = val_q[g*DIGIT_W +: DIGIT_W];
    assign ld_digit[g] = i_load_val[g*DIGIT_W +: DIGIT_W];
  end

  // A digit moves only while every lower digit sits at its terminal value,
  // so the whole ripple settles within one combinational pass.
  always_comb begin
    inc_val      = val_q;
    dec_val      = val_q;
    load_clamped = '0;
    run_max      = 1'b1;
    run_zero     = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (run_max)
        inc_val[k*DIGIT_W +: DIGIT_W] = (digit[k] == DMAX) ? '0 : digit[k] + ONE;
      if (run_zero)
        dec_val[k*DIGIT_W +: DIGIT_W] = (digit[k] == '0) ? DMAX : digit[k] - ONE;
      run_max  = run_max  & (digit[k] == DMAX);
      run_zero = run_zero & (digit[k] == '0);
      load_clamped[k*DIGIT_W +: DIGIT_W] = (ld_digit[k] > DMAX) ? DMAX : ld_digit[k];
    end
    all_max  = run_max;
    all_zero = run_zero;
  end

  // Digits never exceed DMAX, so a plain unsigned compare of the packed
  // vector is the same as a digit-major numeric compare.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      val_q    <= '0;
      hi_q     <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
    end else begin
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      if (i_clr) begin
        if (val_q > hi_q)
          hi_q <= val_q;
        val_q <= '0;
      end else if (i_load) begin
        val_q <= load_clamped;
      end else if (i_inc && !i_dec) begin
        if (!all_max || WRAP)
          val_q <= inc_val;
        carry_q <= all_max && WRAP;
      end else if (i_dec && !i_inc) begin
        if (!all_zero || WRAP)
          val_q <= dec_val;
        borrow_q <= all_zero && WRAP;
      end
    end
  end

  assign o_val    = val_q;
  assign o_hi     = hi_q;
  assign o_carry  = carry_q;
  assign o_borrow = borrow_q;
  assign o_max    = all_max;
  assign o_zero   = (val_q == '0);

endmodule
